// File: rtl/masked_subbytes_seq.sv
// Masked SubBytes sequencer: one shared byte per cycle into the sbox; DonexSO at cycle NBYTES+SBOX_LATENCY+1 after Start.
// No backpressure: the sbox pipeline accepts a byte every cycle and Start is only honoured in IDLE.
module masked_subbytes_seq #(
  parameter int SHARES       = 2,
  parameter int NBYTES       = 16,
  parameter int SBOX_LATENCY = 4
) (
  input  logic                         ClkxCI,
  input  logic                         RstxBI,
  input  logic                         StartxSI,
  input  logic [8*NBYTES*SHARES-1:0]   _StatexDI,
  output logic [8*SHARES-1:0]          _SboxInxDO,
  input  logic [8*SHARES-1:0]          _SboxOutxDI,
  output logic                         RndEnxSO,
  output logic                         BusyxSO,
  output logic                         DonexSO,
  output logic [8*NBYTES*SHARES-1:0]   _StatexDO
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} stateT;

  stateT                       StatexDP;
  logic [CW-1:0]               FeedCntxDP;
  logic [CW-1:0]               CaptCntxDP;
  logic [SBOX_LATENCY-1:0]     ValidxDP;
  logic [SBOX_LATENCY-1:0]     ValidNxtxD;
  logic [8*NBYTES*SHARES-1:0]  InRegxDP;
  logic [8*NBYTES*SHARES-1:0]  ResRegxDP;
  logic                        CaptxS;

  // One token per fed byte; the tail marks the byte now leaving the sbox.
  assign CaptxS     = ValidxDP[SBOX_LATENCY-1];
  assign ValidNxtxD = (ValidxDP << 1) | SBOX_LATENCY'(StatexDP == FEED);
  assign _StatexDO  = ResRegxDP;

  // Each share reads only its own byte lane; shares are never combined.
  always_comb begin
    _SboxInxDO = '0;
    if (StatexDP == FEED) begin
      for (int i = 0; i < SHARES; i++) begin
        _SboxInxDO[i*8 +: 8] = InRegxDP[i*8*NBYTES + int'(FeedCntxDP)*8 +: 8];
      end
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      StatexDP   <= IDLE;
      FeedCntxDP <= '0;
      CaptCntxDP <= '0;
      ValidxDP   <= '0;
      InRegxDP   <= '0;
      ResRegxDP  <= '0;
      RndEnxSO   <= 1'b0;
      BusyxSO    <= 1'b0;
      DonexSO    <= 1'b0;
    end else begin
      ValidxDP <= ValidNxtxD;
      case (StatexDP)
        IDLE: begin
          if (StartxSI) begin
            StatexDP   <= FEED;
            InRegxDP   <= _StatexDI;
            FeedCntxDP <= '0;
            CaptCntxDP <= '0;
            BusyxSO    <= 1'b1;
            RndEnxSO   <= 1'b1;
          end
        end
        FEED, DRAIN: begin
          RndEnxSO <= |ValidNxtxD;
          if (StatexDP == FEED) begin
            if (FeedCntxDP == LastIdx) begin
              StatexDP <= DRAIN;
            end else begin
              FeedCntxDP <= FeedCntxDP + CW'(1);
            end
          end
          if (CaptxS) begin
            // The sbox omits the affine constant; it belongs to share 0 only.
            for (int i = 0; i < SHARES; i++) begin
              ResRegxDP[i*8*NBYTES + int'(CaptCntxDP)*8 +: 8] <=
                _SboxOutxDI[i*8 +: 8] ^ ((i == 0) ? 8'h63 : 8'h00);
            end
            if (CaptCntxDP == LastIdx) begin
              StatexDP <= DONE;
              BusyxSO  <= 1'b0;
              DonexSO  <= 1'b1;
              RndEnxSO <= 1'b0;
            end else begin
              CaptCntxDP <= CaptCntxDP + CW'(1);
            end
          end
        end
        DONE: begin
          StatexDP <= IDLE;
          DonexSO  <= 1'b0;
        end
        default: StatexDP <= IDLE;
      endcase
    end
  end

endmodule
